lock_entry_ctrl: RTL and testbench

- Input and decision stage of the DE-board combination lock.
- Conditions the raw active-low pushbuttons (two-flop synchroniser, debounce, falling-edge pulse).
- Samples the 10 switches on a debounced "enter" press and checks them against the stored code.
- Tracks failed attempts, holds a timed alarm lockout, and drives the 2-bit lock status consumed by the downstream status register and HEX word decoders.

---
 rtl/lock_pkg.sv | 15 +
 rtl/key_debounce.sv | 44 ++++
 rtl/lock_entry_ctrl.sv | 98 +++++++++
 tb/tb_lock_entry_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared status encodings and FSM state type for the combination lock
package lock_pkg;

    localparam logic [1:0] LOCK_ST_LOCKED   = 2'b00;
    localparam logic [1:0] LOCK_ST_UNLOCKED = 2'b01;
    localparam logic [1:0] LOCK_ST_ALARM    = 2'b10;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_CHECK,
        ST_UNLOCKED,
        ST_ALARM
    } lock_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchroniser, debounce counter and press pulse for one active-low button
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    // Only the accepted press (1->0) is announced; releases stay silent
                    pulse <= level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lock_entry_ctrl.sv
// rtl/lock_entry_ctrl.sv - button conditioning, code check, attempt tracking and alarm lockout
module lock_entry_ctrl
    import lock_pkg::*;
#(
    parameter logic [9:0] PASSWORD        = 10'b1010101010,
    parameter int         MAX_ATTEMPTS    = 3,
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         ALARM_CYCLES    = 250000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enter_key_n,
    input  logic       relock_key_n,
    input  logic [9:0] sw,
    output logic [1:0] status,
    output logic [2:0] fail_count,
    output logic       enter_pulse,
    output logic       alarm_led
);

    localparam int         AW       = $clog2(ALARM_CYCLES) + 1;
    localparam logic [2:0] MAX_FAIL = 3'(MAX_ATTEMPTS);

    lock_state_t   state;
    logic          relock_pulse;
    logic [9:0]    code_q;
    logic [AW-1:0] alarm_timer;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (enter_key_n),
        .pulse   (enter_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_relock (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (relock_key_n),
        .pulse   (relock_pulse)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_LOCKED;
            code_q      <= '0;
            fail_count  <= '0;
            alarm_timer <= '0;
            status      <= LOCK_ST_LOCKED;
            alarm_led   <= 1'b0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (enter_pulse) begin
                        code_q <= sw;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (code_q == PASSWORD) begin
                        state      <= ST_UNLOCKED;
                        status     <= LOCK_ST_UNLOCKED;
                        fail_count <= '0;
                    end else if (fail_count + 3'd1 == MAX_FAIL) begin
                        state       <= ST_ALARM;
                        status      <= LOCK_ST_ALARM;
                        alarm_led   <= 1'b1;
                        fail_count  <= MAX_FAIL;
                        alarm_timer <= '0;
                    end else begin
                        fail_count <= fail_count + 3'd1;
                        state      <= ST_LOCKED;
                    end
                end
                ST_UNLOCKED: begin
                    // Relock takes priority; enter is meaningless while open
                    if (relock_pulse) begin
                        state  <= ST_LOCKED;
                        status <= LOCK_ST_LOCKED;
                    end
                end
                ST_ALARM: begin
                    if (alarm_timer == AW'(ALARM_CYCLES - 1)) begin
                        state       <= ST_LOCKED;
                        status      <= LOCK_ST_LOCKED;
                        alarm_led   <= 1'b0;
                        fail_count  <= '0;
                        alarm_timer <= '0;
                    end else begin
                        alarm_timer <= alarm_timer + 1'b1;
                    end
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// tb/tb_lock_entry_ctrl.sv - directed table-driven bench for lock_entry_ctrl
module tb_lock_entry_ctrl;

    logic       clock;
    logic       reset_n;
    logic       enter_key_n;
    logic       relock_key_n;
    logic [9:0] sw;
    logic [1:0] status;
    logic [2:0] fail_count;
    logic       enter_pulse;
    logic       alarm_led;

    int checks = 0;
    int errors = 0;
    int pulse_total = 0;

    typedef struct {
        logic [9:0] code;
        logic [1:0] st;
        logic [2:0] fc;
    } vec_t;

    vec_t vecs[6];

    lock_entry_ctrl #(
        .PASSWORD        (10'b1010101010),
        .MAX_ATTEMPTS    (3),
        .DEBOUNCE_CYCLES (4),
        .ALARM_CYCLES    (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enter_key_n  (enter_key_n),
        .relock_key_n (relock_key_n),
        .sw           (sw),
        .status       (status),
        .fail_count   (fail_count),
        .enter_pulse  (enter_pulse),
        .alarm_led    (alarm_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (enter_pulse) pulse_total++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Press enter with the given code and return at the first negedge the pulse is seen
    task automatic press_enter(input logic [9:0] code, output bit got);
        sw = code;
        enter_key_n = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clock);
            if (enter_pulse) got = 1'b1;
        end
        check("enter_pulse_seen", 32'(got), 32'd1);
    endtask

    task automatic release_keys();
        enter_key_n  = 1'b1;
        relock_key_n = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic press_relock();
        relock_key_n = 1'b0;
        repeat (8) @(negedge clock);
        relock_key_n = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        bit got;
        int base;

        vecs[0] = '{10'h0FF, 2'b00, 3'd1};
        vecs[1] = '{10'h0FF, 2'b00, 3'd2};
        vecs[2] = '{10'h2AA, 2'b01, 3'd0};
        vecs[3] = '{10'h0FF, 2'b00, 3'd1};
        vecs[4] = '{10'h0FF, 2'b00, 3'd2};
        vecs[5] = '{10'h0FF, 2'b10, 3'd3};

        reset_n = 1'b0;
        enter_key_n = 1'b1;
        relock_key_n = 1'b1;
        sw = 10'h000;
        repeat (3) @(negedge clock);
        check("reset_status", 32'(status), 32'h0);
        check("reset_fail", 32'(fail_count), 32'h0);
        check("reset_pulse", 32'(enter_pulse), 32'h0);
        check("reset_alarm", 32'(alarm_led), 32'h0);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("idle_status", 32'(status), 32'h0);
        check("idle_pulses", 32'(pulse_total), 32'd0);

        // Correct code: status stays LOCKED through CHECK, then opens
        base = pulse_total;
        press_enter(10'h2AA, got);
        @(negedge clock);
        sw = 10'h000;
        check("check_cycle_status", 32'(status), 32'h0);
        @(negedge clock);
        check("unlock_status", 32'(status), 32'h1);
        check("unlock_fail", 32'(fail_count), 32'h0);
        release_keys();
        check("single_pulse", 32'(pulse_total - base), 32'd1);
        check("stay_unlocked", 32'(status), 32'h1);
        press_relock();
        check("relock_status", 32'(status), 32'h0);

        // Bouncing enter never stays low long enough to be accepted
        base = pulse_total;
        for (int r = 0; r < 5; r++) begin
            enter_key_n = 1'b0;
            repeat (3) @(negedge clock);
            enter_key_n = 1'b1;
            @(negedge clock);
        end
        repeat (8) @(negedge clock);
        check("bounce_pulses", 32'(pulse_total - base), 32'd0);
        check("bounce_status", 32'(status), 32'h0);

        for (int i = 0; i < 6; i++) begin
            press_enter(vecs[i].code, got);
            @(negedge clock);
            sw = ~vecs[i].code;
            @(negedge clock);
            check($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].st));
            check($sformatf("vec%0d_fail", i), 32'(fail_count), 32'(vecs[i].fc));
            if (vecs[i].st == 2'b10) break;
            release_keys();
            if (i == 2) begin
                // Enter and relock land in the same cycle while open: relock wins
                base = pulse_total;
                enter_key_n = 1'b0;
                relock_key_n = 1'b0;
                repeat (8) @(negedge clock);
                check("both_pulse_seen", 32'(pulse_total - base), 32'd1);
                check("both_status", 32'(status), 32'h0);
                check("both_fail", 32'(fail_count), 32'h0);
                release_keys();
            end
        end

        // ALARM dwell: presses ignored, exit exactly 16 cycles after entry
        check("alarm_led_on", 32'(alarm_led), 32'h1);
        base = pulse_total;
        enter_key_n = 1'b1;
        relock_key_n = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k == 8) enter_key_n = 1'b0;
            if (k == 12) relock_key_n = 1'b1;
            if (k < 16) begin
                check($sformatf("alarm_hold_%0d", k), 32'({status, alarm_led}), 32'({2'b10, 1'b1}));
            end else begin
                check("alarm_exit_status", 32'(status), 32'h0);
                check("alarm_exit_fail", 32'(fail_count), 32'h0);
                check("alarm_exit_led", 32'(alarm_led), 32'h0);
            end
        end
        check("alarm_press_seen", 32'(pulse_total - base), 32'd1);
        release_keys();
        check("post_alarm_status", 32'(status), 32'h0);
        check("post_alarm_fail", 32'(fail_count), 32'h0);

        // Reset in the middle of a second ALARM
        for (int i = 3; i < 6; i++) begin
            press_enter(vecs[i].code, got);
            repeat (2) @(negedge clock);
            if (i < 5) release_keys();
        end
        check("alarm2_status", 32'(status), 32'h2);
        enter_key_n = 1'b1;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midreset_status", 32'(status), 32'h0);
        check("midreset_fail", 32'(fail_count), 32'h0);
        check("midreset_led", 32'(alarm_led), 32'h0);
        repeat (20) @(negedge clock);
        check("after_reset_status", 32'(status), 32'h0);
        check("after_reset_fail", 32'(fail_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
